// File: rtl/adder_sequencer_pkg.sv
// adder_sequencer_pkg: state encodings and default debounce length shared by the adder controller and its bench
package adder_sequencer_pkg;
   localparam logic [1:0] ST_ENTRY_A = 2'b00;
   localparam logic [1:0] ST_ENTRY_B = 2'b01;
   localparam logic [1:0] ST_RESULT  = 2'b10;
   localparam int DEBOUNCE_DEFAULT = 16000;
endpackage

// File: rtl/adder_sequencer_debounce.sv
// adder_sequencer_debounce: synchronizes and debounces one active-low button into a single-cycle press pulse
module adder_sequencer_debounce
   import adder_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_N,
   output logic PRESS
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [1:0] sync, vld;
   logic stable, armed, done;
   logic [CW-1:0] cnt;
   assign done = (sync[1] != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign PRESS = done && stable && armed;
   // sync preset to released; no pulse until a real released sample has been seen, so a button held through reset stays silent
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync <= 2'b11;
         vld <= 2'b00;
         stable <= 1'b1;
         armed <= 1'b0;
         cnt <= '0;
      end else begin
         sync <= {sync[0], BTN_N};
         vld <= {vld[0], 1'b1};
         armed <= armed | (vld[1] & sync[1]);
         cnt <= (sync[1] == stable || done) ? '0 : cnt + 1'b1;
         if (done) stable <= sync[1];
      end
   end
endmodule

// File: rtl/adder_sequencer.sv
// adder_sequencer: button-driven entry of two operands followed by display of their sum
module adder_sequencer
   import adder_sequencer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   SWITCHES,
   input  logic               EXEC_N,
   input  logic               CLR_N,
   output logic [2*WIDTH-1:0] DISPLAY,
   output logic [1:0]         STATE,
   output logic               LED
);
   logic [WIDTH-1:0] sw_s0, sw_s1, a, b;
   logic exec_p, clr_p;
   logic [2*WIDTH-1:0] sw_ext, sum_as, sum_ab;
   assign sw_ext = {{WIDTH{1'b0}}, sw_s1};
   assign sum_as = {{(WIDTH-1){1'b0}}, {1'b0, a} + {1'b0, sw_s1}};
   assign sum_ab = {{(WIDTH-1){1'b0}}, {1'b0, a} + {1'b0, b}};
   adder_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec (
      .CLK(CLK), .RST(RST), .BTN_N(EXEC_N), .PRESS(exec_p)
   );
   adder_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
      .CLK(CLK), .RST(RST), .BTN_N(CLR_N), .PRESS(clr_p)
   );
   // two-flop synchronizer on the operand switches
   always_ff @(posedge CLK) begin
      if (RST) {sw_s1, sw_s0} <= '0;
      else {sw_s1, sw_s0} <= {sw_s0, SWITCHES};
   end
   // entry/result sequencer; CLR acts as a soft reset and beats a same-cycle EXEC
   always_ff @(posedge CLK) begin
      if (RST || clr_p) begin
         STATE <= ST_ENTRY_A;
         a <= '0;
         b <= '0;
         DISPLAY <= '0;
         LED <= 1'b0;
      end else begin
         case (STATE)
            ST_ENTRY_A: begin
               DISPLAY <= sw_ext;
               if (exec_p) begin
                  a <= sw_s1;
                  STATE <= ST_ENTRY_B;
               end
            end
            ST_ENTRY_B: begin
               DISPLAY <= exec_p ? sum_as : sw_ext;
               if (exec_p) begin
                  b <= sw_s1;
                  LED <= 1'b1;
                  STATE <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               DISPLAY <= exec_p ? '0 : sum_ab;
               if (exec_p) begin
                  a <= '0;
                  b <= '0;
                  LED <= 1'b0;
                  STATE <= ST_ENTRY_A;
               end
            end
            default: begin
               STATE <= ST_ENTRY_A;
               a <= '0;
               b <= '0;
               DISPLAY <= '0;
               LED <= 1'b0;
            end
         endcase
      end
   end
endmodule
